// File: rtl/gray_fifo_pkg.sv
// ---------------------------------------------------------------------------
// gray_fifo_pkg
// Shared definitions for the dual-clock FIFO pointer controllers.
//   ADDR_W_DEFAULT : default RAM address width (depth = 2**ADDR_W)
//   wstate_e       : write-side controller states INIT / RUN / FULL
//   bin2gray       : binary to reflected Gray code, b ^ (b >> 1)
// ---------------------------------------------------------------------------
package gray_fifo_pkg;

    localparam int ADDR_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } wstate_e;

    // Works on a 32-bit container; callers zero-extend and truncate to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 32'd1);
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// ---------------------------------------------------------------------------
// gray_to_binary
// Combinational Gray to binary decoder: each binary bit is the XOR of all
// Gray bits at or above its position (prefix XOR from the MSB).
//   W    : code width
//   gray : Gray-coded input, W bits
//   bin  : binary output, W bits
// ---------------------------------------------------------------------------
module gray_to_binary #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/gray_wptr_ctrl.sv
// ---------------------------------------------------------------------------
// gray_wptr_ctrl
// Write-side pointer controller for a dual-clock FIFO. Accepts push
// handshakes, steps a binary write pointer, publishes it in Gray code for the
// read domain and flags full against the synchronised Gray read pointer.
//
// Optional feature macro: GRAY_WPTR_AF_EN adds the almost_full output
// (registered, level >= AF_THRESH) and the AF_THRESH parameter.
//
// Ports:
//   clk            : single clock, rising edge
//   rst_n          : synchronous active-low reset
//   wr_valid       : producer offers a word
//   wr_ready       : controller can accept a word
//   rptr_gray_sync : Gray read pointer, already synchronised into clk
//   wr_en          : RAM write strobe (wr_valid & wr_ready, combinational)
//   waddr          : RAM write address (low bits of the binary pointer)
//   wptr_gray      : registered Gray write pointer for the read domain
//   full           : registered full flag
//   overflow_err   : sticky, set when a push is attempted while full
//   almost_full    : registered almost-full flag (GRAY_WPTR_AF_EN only)
// ---------------------------------------------------------------------------
module gray_wptr_ctrl
    import gray_fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
`ifdef GRAY_WPTR_AF_EN
    , parameter int AF_THRESH = 12
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W:0]   rptr_gray_sync,
    output logic              wr_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              full,
    output logic              overflow_err
`ifdef GRAY_WPTR_AF_EN
    , output logic            almost_full
`endif
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    wstate_e          state_r;
    wstate_e          state_next_s;
    logic [PTR_W-1:0] wbin_r;
    logic [PTR_W-1:0] wptr_gray_r;
    logic             full_r;
    logic             overflow_r;
    logic [PTR_W-1:0] wbin_next_s;
    logic [PTR_W-1:0] wgray_next_s;
    logic [PTR_W-1:0] rptr_full_cmp_s;
    logic             full_cmp_s;
    logic             wr_ready_s;
    logic             wr_en_s;

    // Next-state logic: INIT always yields to RUN; RUN and FULL follow the full compare.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            INIT: state_next_s = RUN;
            RUN: begin
                if (full_cmp_s) begin
                    state_next_s = FULL;
                end else begin
                    state_next_s = RUN;
                end
            end
            FULL: begin
                if (full_cmp_s) begin
                    state_next_s = FULL;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = INIT;
        endcase
    end

    // FSM outputs: ready only in RUN; gating with rst_n kills a push in a reset cycle.
    always_comb begin
        wr_ready_s = 1'b0;
        case (state_r)
            RUN:     wr_ready_s = rst_n;
            INIT:    wr_ready_s = 1'b0;
            FULL:    wr_ready_s = 1'b0;
            default: wr_ready_s = 1'b0;
        endcase
        wr_en_s = wr_valid & wr_ready_s;
    end

    // Pointer datapath: next pointer, its Gray form and the full compare.
    // Full means the next write pointer equals the read pointer one lap ahead;
    // in Gray code that is the read pointer with its top two bits inverted.
    always_comb begin
        if (wr_en_s) begin
            wbin_next_s = wbin_r + PTR_ONE;
        end else begin
            wbin_next_s = wbin_r;
        end
        wgray_next_s    = PTR_W'(bin2gray(32'(wbin_next_s)));
        rptr_full_cmp_s = {~rptr_gray_sync[ADDR_W:ADDR_W-1], rptr_gray_sync[ADDR_W-2:0]};
        full_cmp_s      = (wgray_next_s == rptr_full_cmp_s);
    end

    // State and pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= INIT;
            wbin_r      <= PTR_ZERO;
            wptr_gray_r <= PTR_ZERO;
            full_r      <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            wbin_r      <= wbin_next_s;
            wptr_gray_r <= wgray_next_s;
            full_r      <= full_cmp_s;
            if (wr_valid && (state_r == FULL)) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

`ifdef GRAY_WPTR_AF_EN
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(AF_THRESH);

    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] level_s;
    logic             almost_full_r;

    gray_to_binary #(
        .W(PTR_W)
    ) u_rptr_g2b (
        .gray(rptr_gray_sync),
        .bin (rbin_s)
    );

    // Fill level after this cycle's push; unsigned subtraction wraps modulo 2**PTR_W.
    always_comb begin
        level_s = wbin_next_s - rbin_s;
    end

    // Almost-full register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            almost_full_r <= 1'b0;
        end else begin
            almost_full_r <= (level_s >= AF_LEVEL);
        end
    end

    assign almost_full = almost_full_r;
`endif

    assign wr_ready     = wr_ready_s;
    assign wr_en        = wr_en_s;
    assign waddr        = wbin_r[ADDR_W-1:0];
    assign wptr_gray    = wptr_gray_r;
    assign full         = full_r;
    assign overflow_err = overflow_r;

endmodule

// File: tb/tb_gray_wptr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gray_wptr_ctrl
// Self-checking bench for gray_wptr_ctrl (ADDR_W = 4, depth 16). A directed
// vector table covers reset, fill, overflow and full release; hand sequences
// cover wrap-around, reset mid-burst and almost-full; a random phase is
// checked against a fill-level reference model.
// ---------------------------------------------------------------------------
module tb_gray_wptr_ctrl;

    localparam int AW = 4;
    localparam int PW = 5;
    localparam int AF = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [PW-1:0] rptr_gray_sync = 5'd0;
    logic          wr_en;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr_gray;
    logic          full;
    logic          overflow_err;
`ifdef GRAY_WPTR_AF_EN
    logic          almost_full;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gray_wptr_ctrl #(
        .ADDR_W(AW)
`ifdef GRAY_WPTR_AF_EN
        , .AF_THRESH(AF)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .rptr_gray_sync(rptr_gray_sync),
        .wr_en         (wr_en),
        .waddr         (waddr),
        .wptr_gray     (wptr_gray),
        .full          (full),
        .overflow_err  (overflow_err)
`ifdef GRAY_WPTR_AF_EN
        , .almost_full (almost_full)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] g_of(input int b);
        int t;
        t = b ^ (b >> 1);
        return t[4:0];
    endfunction

    function automatic int b_of(input logic [4:0] g);
        int r;
        r = 0;
        for (int i = 4; i >= 0; i--) begin
            r = (r << 1) | ((r & 1) ^ int'(g[i]));
        end
        return r;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         v;
        logic [4:0] rg;
        bit         rn;
        bit         chk_regs;
        bit         e_rdy;
        bit         e_wen;
        logic [3:0] e_addr;
        logic [4:0] e_gray;
        bit         e_full;
        bit         e_ovf;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input bit v, input logic [4:0] rg, input bit rn, input bit chk,
                                input bit rdy, input bit wen, input logic [3:0] addr,
                                input logic [4:0] gray, input bit f, input bit ovf);
        vec_t r;
        r.v = v; r.rg = rg; r.rn = rn; r.chk_regs = chk;
        r.e_rdy = rdy; r.e_wen = wen; r.e_addr = addr; r.e_gray = gray;
        r.e_full = f; r.e_ovf = ovf;
        return r;
    endfunction

    // ---------------- reference model (fill-level based) ----------------
    int m_bin   = 0;
    bit m_full  = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_af    = 1'b0;
    bit m_init  = 1'b0;
    bit m_known = 1'b0;

    task automatic cycle(input bit v, input logic [4:0] rg, input bit rn);
        bit rdy;
        bit push;
        int nb;
        int lvl;
        @(negedge clk);
        wr_valid       = v;
        rptr_gray_sync = rg;
        rst_n          = rn;
        #1;
        rdy = rn && m_known && !m_init && !m_full;
        check("wr_ready", wr_ready, rdy);
        check("wr_en", wr_en, v && rdy);
        if (m_known) begin
            check("waddr", waddr, m_bin % 16);
            check("wptr_gray", wptr_gray, g_of(m_bin));
            check("full", full, m_full);
            check("overflow_err", overflow_err, m_ovf);
`ifdef GRAY_WPTR_AF_EN
            check("almost_full", almost_full, m_af);
`endif
        end
        if (!rn) begin
            m_bin = 0; m_full = 0; m_ovf = 0; m_af = 0; m_init = 1; m_known = 1;
        end else begin
            push = v && rdy;
            if (v && m_full && !m_init) m_ovf = 1'b1;
            nb = (m_bin + int'(push)) % 32;
            lvl = (nb - b_of(rg)) & 31;
            m_full = (lvl == 16);
            m_af   = (lvl >= AF);
            m_init = 1'b0;
            m_bin  = nb;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] gd1;
        logic [4:0] gd2;
        logic [4:0] prev_g;
        logic [4:0] cur_g;
        int rd_bin;
        bit rn;
        bit v;

        // Build the directed table.
        tbl[0] = mk(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
        tbl[1] = mk(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
        tbl[2] = mk(1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
        for (int p = 0; p < 16; p++) begin
            tbl[3 + p] = mk(1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'(p), g_of(p), 1'b0, 1'b0);
        end
        tbl[19] = mk(1'b1, 5'd0,     1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b0);
        tbl[20] = mk(1'b1, 5'd0,     1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1);
        tbl[21] = mk(1'b1, 5'd0,     1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1);
        tbl[22] = mk(1'b0, 5'b00001, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1);
        tbl[23] = mk(1'b1, 5'b00001, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 5'b11000, 1'b0, 1'b1);
        tbl[24] = mk(1'b0, 5'b00001, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 5'b11001, 1'b1, 1'b1);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            wr_valid       = tbl[i].v;
            rptr_gray_sync = tbl[i].rg;
            rst_n          = tbl[i].rn;
            #1;
            check($sformatf("tbl%0d_ready", i), wr_ready, tbl[i].e_rdy);
            check($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].e_wen);
            if (tbl[i].chk_regs) begin
                check($sformatf("tbl%0d_waddr", i), waddr, tbl[i].e_addr);
                check($sformatf("tbl%0d_gray", i), wptr_gray, tbl[i].e_gray);
                check($sformatf("tbl%0d_full", i), full, tbl[i].e_full);
                check($sformatf("tbl%0d_ovf", i), overflow_err, tbl[i].e_ovf);
            end
        end

        // Wrap-around: 40 pushes with the read pointer two cycles behind.
        cycle(1'b0, 5'd0, 1'b0);
        cycle(1'b0, 5'd0, 1'b0);
        cycle(1'b0, 5'd0, 1'b1);
        gd1 = 5'd0;
        gd2 = 5'd0;
        prev_g = 5'd0;
        for (int k = 0; k < 40; k++) begin
            cycle(1'b1, gd2, 1'b1);
            cur_g = wptr_gray;
            if (cur_g !== prev_g) check("gray_one_bit", $countones(cur_g ^ prev_g), 1);
            prev_g = cur_g;
            gd2 = gd1;
            gd1 = g_of(m_bin);
        end
        cycle(1'b0, gd2, 1'b1);
        check("wrap_waddr", waddr, 4'd8);
        check("wrap_gray", wptr_gray, g_of(40 % 32));

        // Reset in the middle of a burst: no strobe in the reset cycle, all zero after.
        cycle(1'b1, gd2, 1'b1);
        cycle(1'b1, gd2, 1'b1);
        cycle(1'b1, gd2, 1'b0);
        check("rst_burst_wr_en", wr_en, 1'b0);
        cycle(1'b1, 5'd0, 1'b0);
        check("rst_burst_waddr", waddr, 4'd0);
        check("rst_burst_full", full, 1'b0);

        // Almost-full ramp with the read pointer at 0.
        cycle(1'b0, 5'd0, 1'b1);
        for (int k = 0; k < 14; k++) cycle(1'b1, 5'd0, 1'b1);
        cycle(1'b0, 5'd0, 1'b1);
`ifdef GRAY_WPTR_AF_EN
        check("af_after_14", almost_full, 1'b1);
`endif

        // Randomised traffic with a read side that drains at random.
        cycle(1'b0, 5'd0, 1'b0);
        rd_bin = 0;
        for (int k = 0; k < 500; k++) begin
            rn = ($urandom_range(0, 99) != 0);
            v  = ($urandom_range(0, 3) != 0);
            if (!rn) begin
                rd_bin = 0;
            end else if ((((m_bin - rd_bin) & 31) != 0) && ($urandom_range(0, 2) == 0)) begin
                rd_bin = (rd_bin + 1) % 32;
            end
            cycle(v, g_of(rd_bin), rn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
